mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl_if.sv | 42 ++++
 rtl/mem_bus_ctrl.sv | 113 +++++++++++
 tb/tb_mem_bus_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Pipeline-side access port and external memory bus of mem_bus_ctrl.
// master is the controller's view, slave the environment's view.
interface mem_bus_ctrl_if;
  logic        acc_req;
  logic        acc_we;
  logic [3:0]  acc_be;
  logic [31:0] paddr_in;
  logic        mmu_error_in;
  logic [31:0] wdata_in;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        fault_o;
  logic [1:0]  fault_code_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    input  acc_req, acc_we, acc_be, paddr_in,
    input  mmu_error_in, wdata_in,
    input  bus_ack_i, bus_rdata_i,
    output stall_o, rdata_o, done_o, fault_o,
    output fault_code_o,
    output bus_req_o, bus_we_o, bus_addr_o,
    output bus_be_o, bus_wdata_o
  );

  modport slave (
    output acc_req, acc_we, acc_be, paddr_in,
    output mmu_error_in, wdata_in,
    output bus_ack_i, bus_rdata_i,
    input  stall_o, rdata_o, done_o, fault_o,
    input  fault_code_o,
    input  bus_req_o, bus_we_o, bus_addr_o,
    input  bus_be_o, bus_wdata_o
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory access controller: checks alignment/MMU faults, runs one bus
// cycle with a wait-state timeout, and reports done/fault pulses.
module mem_bus_ctrl #(
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           clr_n,
  mem_bus_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUS   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_we;
  logic [1:0]  r_fcode;

  logic w_mis;
  logic w_ok;
  logic w_idle;
  logic w_busy;

  always_comb begin
    w_mis = 1'b1;
    unique case (1'b1)
      (bus.acc_be == 4'b1111):
        w_mis = (bus.paddr_in[1:0] != 2'b00);
      (bus.acc_be == 4'b0011),
      (bus.acc_be == 4'b1100):
        w_mis = bus.paddr_in[0];
      (bus.acc_be == 4'b0001),
      (bus.acc_be == 4'b0010),
      (bus.acc_be == 4'b0100),
      (bus.acc_be == 4'b1000):
        w_mis = 1'b0;
      default:
        w_mis = 1'b1;
    endcase
  end

  assign w_idle = (r_state == S_IDLE);
  assign w_busy = (r_state == S_BUS);
  assign w_ok   = bus.acc_req & ~bus.mmu_error_in & ~w_mis;

  // Gated by clr_n so the pipeline is never frozen while held in reset.
  assign bus.stall_o = clr_n & ((w_idle & w_ok) | w_busy);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_rdata <= 32'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_we    <= 1'b0;
      r_fcode <= 2'b00;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.acc_req) begin
            if (bus.mmu_error_in) begin
              r_fcode <= 2'b01;
              r_state <= S_FAULT;
            end else if (w_mis) begin
              r_fcode <= 2'b10;
              r_state <= S_FAULT;
            end else begin
              r_addr  <= bus.paddr_in;
              r_we    <= bus.acc_we;
              r_be    <= bus.acc_be;
              r_wdata <= bus.wdata_in;
              r_cnt   <= 8'd0;
              r_state <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (bus.bus_ack_i) begin
            if (!r_we) r_rdata <= bus.bus_rdata_i;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_fcode <= 2'b11;
            r_state <= S_FAULT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata_o      = r_rdata;
  assign bus.done_o       = (r_state == S_DONE);
  assign bus.fault_o      = (r_state == S_FAULT);
  assign bus.fault_code_o = r_fcode;
  assign bus.bus_req_o    = w_busy;
  assign bus.bus_we_o     = r_we;
  assign bus.bus_addr_o   = r_addr;
  assign bus.bus_be_o     = r_be;
  assign bus.bus_wdata_o  = r_wdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: directed and random accesses,
// bus responder with programmable wait states, reset checks.
module tb_mem_bus_ctrl;

  localparam int TIMEOUT = 15;

  typedef struct {
    bit          is_fault;
    logic [1:0]  code;
    logic [31:0] rdata;
    int          len;
  } exp_t;

  logic clk;
  logic clr_n;
  mem_bus_ctrl_if bif ();

  mem_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bif)
  );

  int n_chk  = 0;
  int n_fail = 0;
  exp_t q[$];

  logic [31:0] m_rdata;
  logic [1:0]  m_fcode;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] cur_rdata;
  logic [3:0]  cur_be;
  logic        cur_we;
  int          cur_delay;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit ref_mis(logic [3:0] be, logic [31:0] a);
    int sz;
    case (be)
      4'b1111: sz = 4;
      4'b0011, 4'b1100: sz = 2;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 1;
      default: return 1'b1;
    endcase
    return (a % sz) != 0;
  endfunction

  task automatic check_zero(string tag);
    check({tag, "_stall"}, 32'(bif.stall_o), 32'd0);
    check({tag, "_done"}, 32'(bif.done_o), 32'd0);
    check({tag, "_fault"}, 32'(bif.fault_o), 32'd0);
    check({tag, "_fcode"}, 32'(bif.fault_code_o), 32'd0);
    check({tag, "_rdata"}, bif.rdata_o, 32'd0);
    check({tag, "_breq"}, 32'(bif.bus_req_o), 32'd0);
    check({tag, "_bwe"}, 32'(bif.bus_we_o), 32'd0);
    check({tag, "_baddr"}, bif.bus_addr_o, 32'd0);
    check({tag, "_bbe"}, 32'(bif.bus_be_o), 32'd0);
    check({tag, "_bwdata"}, bif.bus_wdata_o, 32'd0);
  endtask

  task automatic access(bit we, logic [3:0] be, logic [31:0] addr,
                        logic [31:0] wd, bit mmu, int delay,
                        logic [31:0] rd);
    exp_t e;
    bit   mis;
    int   t;
    mis     = ref_mis(be, addr);
    e.rdata = m_rdata;
    e.code  = m_fcode;
    if (mmu) begin
      e.is_fault = 1; e.code = 2'b01; e.len = 0;
    end else if (mis) begin
      e.is_fault = 1; e.code = 2'b10; e.len = 0;
    end else if (delay >= TIMEOUT) begin
      e.is_fault = 1; e.code = 2'b11; e.len = TIMEOUT;
    end else begin
      e.is_fault = 0; e.len = delay + 1;
      if (!we) e.rdata = rd;
    end
    m_rdata = e.rdata;
    m_fcode = e.code;
    @(negedge clk);
    cur_addr = addr; cur_we = we; cur_be = be;
    cur_wdata = wd; cur_delay = delay; cur_rdata = rd;
    bif.acc_we = we; bif.acc_be = be; bif.paddr_in = addr;
    bif.wdata_in = wd; bif.mmu_error_in = mmu;
    bif.acc_req = 1'b1;
    q.push_back(e);
    #1;
    check("stall_idle", 32'(bif.stall_o), 32'(!mmu && !mis));
    @(posedge clk);
    #1;
    bif.acc_req = $urandom_range(0, 1);
    bif.acc_we = $urandom_range(0, 1);
    bif.acc_be = 4'($urandom);
    bif.paddr_in = $urandom;
    bif.wdata_in = $urandom;
    bif.mmu_error_in = $urandom_range(0, 1);
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (q.size() != 0) begin
      check("resp_wait", 32'(q.size()), 32'd0);
      q.delete();
    end
    bif.acc_req = 1'b0;
  endtask

  // Bus responder and scoreboard monitor.
  initial begin
    int   k;
    int   last_len;
    exp_t e;
    k = 0;
    last_len = 0;
    bif.bus_ack_i = 1'b0;
    bif.bus_rdata_i = 32'd0;
    forever begin
      @(negedge clk);
      if (!clr_n) begin
        k = 0; last_len = 0; bif.bus_ack_i = 1'b0;
        continue;
      end
      if (bif.bus_req_o) begin
        k++;
        check("stall_bus", 32'(bif.stall_o), 32'd1);
        check("bus_addr", bif.bus_addr_o, cur_addr);
        check("bus_we", 32'(bif.bus_we_o), 32'(cur_we));
        check("bus_be", 32'(bif.bus_be_o), 32'(cur_be));
        check("bus_wdata", bif.bus_wdata_o, cur_wdata);
        bif.bus_ack_i = (k == cur_delay + 1);
        bif.bus_rdata_i = bif.bus_ack_i ? cur_rdata : $urandom;
      end else begin
        if (k > 0) last_len = k;
        k = 0;
        bif.bus_ack_i = 1'($urandom_range(0, 1));
        bif.bus_rdata_i = $urandom;
      end
      if (bif.done_o || bif.fault_o) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          check("fault_o", 32'(bif.fault_o), 32'(e.is_fault));
          check("done_o", 32'(bif.done_o), 32'(!e.is_fault));
          check("fault_code", 32'(bif.fault_code_o), 32'(e.code));
          check("rdata", bif.rdata_o, e.rdata);
          check("bus_len", 32'(last_len), 32'(e.len));
          check("stall_end", 32'(bif.stall_o), 32'd0);
        end
        last_len = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] be_list [7];
    logic [3:0] be;
    int         r;
    int         dly;
    be_list = '{4'b1111, 4'b0011, 4'b1100, 4'b0001,
                4'b0010, 4'b0100, 4'b1000};
    m_rdata = 32'd0;
    m_fcode = 2'b00;
    cur_delay = 0;
    clr_n = 1'b0;
    bif.acc_req = 1'b1;
    bif.acc_we = 1'b0;
    bif.acc_be = 4'b1111;
    bif.paddr_in = 32'h0000_1000;
    bif.wdata_in = 32'd0;
    bif.mmu_error_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst0");
    #1;
    bif.acc_req = 1'b0;
    clr_n = 1'b1;

    access(0, 4'b1111, 32'h0000_1000, 32'd0, 0, 0, 32'hDEAD_BEEF);
    access(1, 4'b0011, 32'h0000_2002, 32'h1234_5678, 0, 3, 32'h0);
    access(0, 4'b1111, 32'h0000_3001, 32'd0, 1, 0, 32'h0);
    access(0, 4'b1111, 32'h0000_0006, 32'd0, 0, 0, 32'h0);
    access(0, 4'b0001, 32'h0000_0044, 32'd0, 0, 100, 32'h5555_AAAA);
    access(0, 4'b0100, 32'h0000_0045, 32'd0, 0, TIMEOUT - 1, 32'hCAFE_F00D);
    access(1, 4'b0110, 32'h0000_0010, 32'd7, 0, 0, 32'h0);

    // Reset two cycles into a bus cycle.
    @(negedge clk);
    cur_addr = 32'h0000_4000; cur_we = 1'b0; cur_be = 4'b1111;
    cur_wdata = 32'd0; cur_delay = 1000; cur_rdata = 32'h0;
    bif.acc_we = 1'b0; bif.acc_be = 4'b1111;
    bif.paddr_in = 32'h0000_4000; bif.mmu_error_in = 1'b0;
    bif.wdata_in = 32'd0;
    bif.acc_req = 1'b1;
    @(posedge clk);
    #1;
    bif.acc_req = 1'b0;
    @(posedge clk);
    #3;
    check("rstbus_breq_before", 32'(bif.bus_req_o), 32'd1);
    bif.acc_req = 1'b1;
    clr_n = 1'b0;
    #1;
    check_zero("rstbus");
    m_rdata = 32'd0;
    m_fcode = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    bif.acc_req = 1'b0;
    clr_n = 1'b1;
    access(0, 4'b1111, 32'h0000_5000, 32'd0, 0, 1, 32'h0BAD_F00D);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) be = be_list[r];
      else be = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7) dly = $urandom_range(0, 4);
      else dly = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
      access(1'($urandom_range(0, 1)), be, $urandom, $urandom,
             ($urandom_range(0, 7) == 0), dly, $urandom);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
